// File: rtl/mul_issue_ctrl.sv
// Issue/stall controller in front of the iterative multiplier: latches operands, pulses start,
// holds EX until done or watchdog expiry, and short-circuits exact repeats through a one-entry cache.
module mul_issue_ctrl #(
  parameter int TIMEOUT  = 40,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rdE,
  input  logic [31:0] rs1_dataE,
  input  logic [31:0] rs2_dataE,
  input  logic        flushE,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        startE,
  output logic [1:0]  mul_opcode,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  output logic        stall_mul,
  output logic        result_valid,
  output logic [31:0] resultM,
  output logic [4:0]  rdM,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_WB} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  wait_cnt;
  logic           cache_vld;
  logic [1:0]     cache_op;
  logic [31:0]    cache_a, cache_b, cache_res;
  logic           accept, hit, cnt_last;

  assign accept   = (state == S_IDLE) && valid_m && !funct3[2] && !flushE;
  assign hit      = CACHE_EN && cache_vld && (cache_op == funct3[1:0]) &&
                    (cache_a == rs1_dataE) && (cache_b == rs2_dataE);
  assign cnt_last = (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx     = state;
    startE       = 1'b0;
    stall_mul    = accept;
    result_valid = 1'b0;
    busy         = (state != S_IDLE);
    timeout_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = hit ? S_WB : S_START;
      end
      S_START: begin
        stall_mul = 1'b1;
        if (flushE) begin
          state_nx = S_IDLE;
        end else begin
          startE   = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_mul = 1'b1;
        // flush beats done, done beats the watchdog
        if (flushE) begin
          state_nx = S_IDLE;
        end else if (mul_done) begin
          state_nx = S_WB;
        end else if (cnt_last) begin
          timeout_err = 1'b1;
          state_nx    = S_WB;
        end
      end
      S_WB: begin
        result_valid = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      cache_vld  <= 1'b0;
      cache_op   <= '0;
      cache_a    <= '0;
      cache_b    <= '0;
      cache_res  <= '0;
      mul_opcode <= '0;
      operand1   <= '0;
      operand2   <= '0;
      resultM    <= '0;
      rdM        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_opcode <= funct3[1:0];
            operand1   <= rs1_dataE;
            operand2   <= rs2_dataE;
            rdM        <= rdE;
            if (hit) resultM <= cache_res;
          end
        end
        S_START: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (!flushE) begin
            if (mul_done) begin
              resultM   <= mul_result;
              cache_vld <= 1'b1;
              cache_op  <= mul_opcode;
              cache_a   <= operand1;
              cache_b   <= operand2;
              cache_res <= mul_result;
            end else if (cnt_last) begin
              resultM <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a schedule-based model of the issue/stall behaviour.
module tb_mul_issue_ctrl;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst, valid_m, flushE, mul_done;
  logic [2:0]  funct3;
  logic [4:0]  rdE;
  logic [31:0] rs1_dataE, rs2_dataE, mul_result;
  logic        startE, stall_mul, result_valid, busy, timeout_err;
  logic [1:0]  mul_opcode;
  logic [31:0] operand1, operand2, resultM;
  logic [4:0]  rdM;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.TIMEOUT(TIMEOUT), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .funct3(funct3), .rdE(rdE),
    .rs1_dataE(rs1_dataE), .rs2_dataE(rs2_dataE), .flushE(flushE),
    .mul_done(mul_done), .mul_result(mul_result), .startE(startE),
    .mul_opcode(mul_opcode), .operand1(operand1), .operand2(operand2),
    .stall_mul(stall_mul), .result_valid(result_valid), .resultM(resultM),
    .rdM(rdM), .busy(busy), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      2'd0:    p = ua * ub;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Model: an accepted op is tracked by its accept cycle; START/WAIT/WB are cycle offsets from it.
  longint      cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_live = 1'b0, m_hit = 1'b0;
  longint      m_acc = 0, m_wb = -1;
  logic [1:0]  e_op = '0;
  logic [31:0] e_a = '0, e_b = '0, e_res = '0;
  logic [4:0]  e_rd = '0;
  bit          c_vld = 1'b0;
  logic [1:0]  c_op = '0;
  logic [31:0] c_a = '0, c_b = '0, c_res = '0;
  bit          last_stall = 1'b0;
  longint      stub_due = -1;
  logic [31:0] stub_res = '0;
  int          stub_lat = 1;
  bit          rand_mode = 1'b0;

  always @(negedge clk) begin
    automatic bit     idle, is_start, is_wait, is_wb, acc, hit, e_start, e_stall, e_tmo;
    automatic longint wk;
    idle     = !m_live;
    is_start = m_live && !m_hit && (cyc == m_acc + 1);
    is_wait  = m_live && !m_hit && (m_wb < 0) && (cyc >= m_acc + 2);
    is_wb    = m_live && (cyc == m_wb);
    wk       = cyc - (m_acc + 1);
    acc      = idle && valid_m && !funct3[2] && !flushE;
    hit      = c_vld && (c_op == funct3[1:0]) && (c_a == rs1_dataE) && (c_b == rs2_dataE);
    e_start  = is_start && !flushE;
    e_stall  = acc || is_start || is_wait;
    e_tmo    = is_wait && (wk == TIMEOUT) && !mul_done && !flushE;
    if (chk_en) begin
      chk("startE", 32'(startE), 32'(e_start));
      chk("stall_mul", 32'(stall_mul), 32'(e_stall));
      chk("result_valid", 32'(result_valid), 32'(is_wb));
      chk("busy", 32'(busy), 32'(!idle));
      chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
      chk("mul_opcode", 32'(mul_opcode), 32'(e_op));
      chk("operand1", operand1, e_a);
      chk("operand2", operand2, e_b);
      chk("resultM", resultM, e_res);
      chk("rdM", 32'(rdM), 32'(e_rd));
    end
    last_stall = e_stall;
    if (e_start) begin
      stub_due = (stub_lat > 0) ? cyc + stub_lat : -1;
      stub_res = prod(e_op, e_a, e_b);
    end
    if (rst) begin
      m_live = 1'b0; c_vld = 1'b0; m_wb = -1;
      e_op = '0; e_a = '0; e_b = '0; e_res = '0; e_rd = '0;
    end else if (acc) begin
      m_live = 1'b1; m_acc = cyc; m_hit = hit;
      e_op = funct3[1:0]; e_a = rs1_dataE; e_b = rs2_dataE; e_rd = rdE;
      if (hit) begin e_res = c_res; m_wb = cyc + 1; end
      else m_wb = -1;
    end else if (is_start && flushE) begin
      m_live = 1'b0;
    end else if (is_wait) begin
      if (flushE) m_live = 1'b0;
      else if (mul_done) begin
        e_res = mul_result; m_wb = cyc + 1;
        c_vld = 1'b1; c_op = e_op; c_a = e_a; c_b = e_b; c_res = mul_result;
      end else if (wk == TIMEOUT) begin
        e_res = '0; m_wb = cyc + 1;
      end
    end else if (is_wb) begin
      m_live = 1'b0;
    end
    cyc++;
  end

  // Driver: request variables are applied just after each rising edge; the multiplier stub lives here.
  logic        req_rst = 1'b1, req_valid = 1'b0, req_flush = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_a = '0, req_b = '0;

  task automatic step();
    bit stray;
    @(posedge clk);
    #1;
    rst = req_rst; valid_m = req_valid; flushE = req_flush;
    funct3 = req_f3; rdE = req_rd; rs1_dataE = req_a; rs2_dataE = req_b;
    stray = rand_mode && ($urandom_range(0, 39) == 0);
    mul_done   = (stub_due == cyc) || stray;
    mul_result = (stub_due == cyc) ? stub_res : $urandom;
    @(negedge clk);
    #1;
  endtask

  int          o_starts, o_start_off, o_rv_off, o_tmo_off, o_stall_gap;
  logic [31:0] o_res;
  logic [4:0]  o_rd;

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input int lat);
    stub_lat = lat;
    req_valid = 1'b1; req_f3 = f3; req_rd = rd; req_a = a; req_b = b;
    o_starts = 0; o_start_off = -1; o_rv_off = -1; o_tmo_off = -1; o_stall_gap = 0;
    o_res = '0; o_rd = '0;
    for (int k = 0; k < 100 && o_rv_off < 0; k++) begin
      step();
      if (startE) begin o_starts++; if (o_start_off < 0) o_start_off = k; end
      if (timeout_err && o_tmo_off < 0) o_tmo_off = k;
      if (result_valid) begin o_rv_off = k; o_res = resultM; o_rd = rdM; end
      else if (!stall_mul) o_stall_gap++;
    end
    req_valid = 1'b0;
    if (o_rv_off < 0) begin
      checks++; errors++;
      $display("FAIL issue_bound: no result_valid within 100 cycles, got none expected one");
    end
    step();
    chk("rv_single_cycle", 32'(result_valid), 32'd0);
  endtask

  initial begin
    int rv_cnt;
    rst = 1'b1; valid_m = 1'b0; flushE = 1'b0; funct3 = '0; rdE = '0;
    rs1_dataE = '0; rs2_dataE = '0; mul_done = 1'b0; mul_result = '0;

    step(); step();
    chk_en = 1'b1;
    req_rst = 1'b0;
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_resultM", resultM, 32'd0);
    chk("reset_stall", 32'(stall_mul), 32'd0);

    // MUL 7x6 -> 42, done on WAIT cycle 34
    issue(3'b000, 5'd5, 32'd7, 32'd6, 34);
    chk("t1_starts", 32'(o_starts), 32'd1);
    chk("t1_start_off", 32'(o_start_off), 32'd1);
    chk("t1_rv_off", 32'(o_rv_off), 32'd36);
    chk("t1_stall_gap", 32'(o_stall_gap), 32'd0);
    chk("t1_res", o_res, 32'd42);
    chk("t1_rd", 32'(o_rd), 32'd5);
    chk("t1_hold", resultM, 32'd42);

    // MULHU all-ones, then the identical op hits the cache
    issue(3'b011, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    chk("t2_res", o_res, 32'hFFFF_FFFE);
    issue(3'b011, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    chk("t2_hit_starts", 32'(o_starts), 32'd0);
    chk("t2_hit_rv_off", 32'(o_rv_off), 32'd1);
    chk("t2_hit_res", o_res, 32'hFFFF_FFFE);

    // opcode change misses
    issue(3'b000, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    chk("t3_starts", 32'(o_starts), 32'd1);
    chk("t3_opcode", 32'(mul_opcode), 32'd0);
    chk("t3_res", o_res, 32'd1);

    // flush on the 10th WAIT cycle; the stale done 20 cycles later must be ignored
    stub_lat = 30;
    req_valid = 1'b1; req_f3 = 3'b000; req_rd = 5'd9; req_a = 32'd9; req_b = 32'd9;
    step(); step();
    for (int i = 0; i < 9; i++) step();
    req_flush = 1'b1;
    step();
    chk("t4_flush_cycle_stall", 32'(stall_mul), 32'd1);
    req_flush = 1'b0; req_valid = 1'b0;
    step();
    chk("t4_after_flush_stall", 32'(stall_mul), 32'd0);
    chk("t4_after_flush_busy", 32'(busy), 32'd0);
    rv_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (result_valid) rv_cnt++;
    end
    chk("t4_no_result", 32'(rv_cnt), 32'd0);
    issue(3'b000, 5'd3, 32'd3, 32'd4, 3);
    chk("t4_new_res", o_res, 32'd12);

    // watchdog: done never arrives
    issue(3'b000, 5'd7, 32'd11, 32'd13, 0);
    chk("t5_tmo_off", 32'(o_tmo_off), 32'd41);
    chk("t5_rv_off", 32'(o_rv_off), 32'd42);
    chk("t5_res", o_res, 32'd0);
    issue(3'b000, 5'd7, 32'd11, 32'd13, 2);
    chk("t5_retry_starts", 32'(o_starts), 32'd1);
    chk("t5_retry_res", o_res, 32'd143);

    // divide encodings are never accepted
    req_valid = 1'b1; req_f3 = 3'b100; req_a = 32'd8; req_b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall", 32'(stall_mul), 32'd0);
      chk("t6_start", 32'(startE), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
    end
    req_valid = 1'b0;
    step();

    // reset during WAIT clears outputs and the cache
    issue(3'b000, 5'd1, 32'd5, 32'd5, 4);
    stub_lat = 20;
    req_valid = 1'b1; req_f3 = 3'b000; req_rd = 5'd2; req_a = 32'd2; req_b = 32'd8;
    for (int i = 0; i < 7; i++) step();
    req_rst = 1'b1;
    step();
    req_rst = 1'b0; req_valid = 1'b0;
    step();
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_stall", 32'(stall_mul), 32'd0);
    chk("t7_resultM", resultM, 32'd0);
    chk("t7_rdM", 32'(rdM), 32'd0);
    chk("t7_operand1", operand1, 32'd0);
    for (int i = 0; i < 20; i++) step();
    issue(3'b000, 5'd1, 32'd5, 32'd5, 4);
    chk("t7_cache_cleared", 32'(o_starts), 32'd1);
    chk("t7_res", o_res, 32'd25);

    // random traffic: the instruction is held in EX while the model says the pipeline stalls
    rand_mode = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (!last_stall || req_flush || req_rst) begin
        logic [31:0] pool [4];
        pool[0] = 32'd3; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'd12345;
        req_valid = ($urandom_range(0, 2) != 0);
        req_f3    = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
        req_rd    = 5'($urandom);
        req_a     = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
        req_b     = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
        stub_lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 45);
      end
      req_flush = ($urandom_range(0, 24) == 0);
      req_rst   = ($urandom_range(0, 399) == 0);
      step();
    end
    rand_mode = 1'b0;
    req_valid = 1'b0; req_flush = 1'b0; req_rst = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Execute-stage issue/stall controller that sits directly upstream of the iterative multiplier.
- Decodes an RV32M multiply in EX, latches its operands and issues a one-cycle start pulse.
- Holds the pipeline stalled until the multiplier reports done, then hands the 32-bit result and rd to the MEM/WB path for one cycle.
- A single-entry result cache skips the multiplier on back-to-back identical multiplies; a watchdog releases the pipeline if done never arrives.

Parameters:
TIMEOUT, 40, max WAIT cycles before abandoning an operation (must be >= 35)
CACHE_EN, 1, 1 enables the single-entry result cache; 0 forces every multiply through the multiplier

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_m  input  1  EX holds an M-extension instruction
funct3  input  3  instruction funct3
rdE  input  5  destination register of the EX instruction
rs1_dataE  input  32  forwarded rs1 value
rs2_dataE  input  32  forwarded rs2 value
flushE  input  1  kill the instruction in EX
mul_done  input  1  multiplier completion strobe
mul_result  input  32  multiplier result, valid with mul_done
startE  output  1  one-cycle start pulse to the multiplier
mul_opcode  output  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
operand1  output  32  latched rs1
operand2  output  32  latched rs2
stall_mul  output  1  freeze IF/ID/EX (combinational)
result_valid  output  1  one-cycle result strobe to MEM/WB
resultM  output  32  result
rdM  output  5  destination register paired with resultM
busy  output  1  state != IDLE
timeout_err  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; cache invalid; wait counter 0.
- Acceptance condition `accept` = state==IDLE && valid_m && !funct3[2] && !flushE.
  - funct3 1xx (divide/remainder) is never accepted.
  - mul_opcode = funct3[1:0].
- stall_mul = accept || state==START || state==WAIT. It is low in WB, so the EX instruction leaves at the end of the WB cycle.
- State IDLE:
  - On accept, register operand1/operand2/mul_opcode/rdM.
  - Cache hit: CACHE_EN && cache valid && opcode and both operands equal the cached ones. Load resultM from the cache and go to WB; startE is not pulsed.
  - Otherwise go to START.
  - mul_done is ignored in IDLE.
- State START: startE=1 for exactly this cycle; clear the wait counter; go to WAIT. mul_done is ignored.
- State WAIT:
  - Increment the wait counter each cycle.
  - On mul_done: resultM <= mul_result, update the cache (opcode, operands, result, valid), go to WB.
  - If the counter reaches TIMEOUT-1 without done: timeout_err=1 for one cycle, resultM <= 0, cache untouched, go to WB.
  - If mul_done and timeout occur in the same cycle, mul_done wins.
- State WB: result_valid=1 for exactly one cycle with resultM/rdM stable; go to IDLE. No new acceptance in WB, even though valid_m may still be high.
- Flush:
  - flushE in START or WAIT: go to IDLE next edge; no result_valid, no cache update, no timeout_err. startE is suppressed if flushE arrives in START.
  - A later done from the abandoned operation is ignored.
  - flushE in WB has no effect (the result is already committed).
- rdE=0 is processed normally (writeback discards x0). resultM and rdM hold their value after WB until the next capture.
- Reset mid-operation: immediate return to IDLE; cache invalidated; any stale later done is ignored.
- Latency:
  - Cache hit: accept edge, then WB, so result_valid appears 1 cycle after accept (stall is 1 cycle).
  - Miss: result_valid appears on the cycle after mul_done is seen.

Test Plan:
- MUL, rs1=7, rs2=6, rdE=5; stub returns done with 42 after 34 cycles -> startE pulses once exactly 1 cycle after accept; stall_mul high from accept through WAIT; result_valid single cycle with resultM=42, rdM=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF (stub result 0xFFFFFFFE), then the identical instruction again -> second has no startE; result_valid 1 cycle after accept with 0xFFFFFFFE.
- Same operands but funct3 changes 011->000 -> cache miss; startE pulses, mul_opcode=00.
- flushE in the 10th WAIT cycle -> IDLE next cycle, stall_mul drops, no result_valid; a stub done 20 cycles later is ignored. A new MUL 3x4 then yields 12.
- mul_done held low, TIMEOUT=40 -> timeout_err pulses on the 40th WAIT cycle; result_valid follows with resultM=0; the next identical op is a miss.
- funct3=100 with valid_m=1 -> no stall, no startE, busy=0. rst asserted during WAIT -> all outputs 0 next cycle, cache cleared.
